// File: rtl/io_input_port_if.sv
// Processor-side IO read bus of the input port: word address, read strobe, read data and event line.
interface io_input_port_if;
  logic [3:0]  io_addr;
  logic        io_read_en;
  logic [31:0] io_read_data;
  logic        event_pending;

  modport master (
    output io_addr,
    output io_read_en,
    input  io_read_data,
    input  event_pending
  );

  modport slave (
    input  io_addr,
    input  io_read_en,
    output io_read_data,
    output event_pending
  );
endinterface

// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronizes and debounces switches/buttons, latches sticky press flags
// and a wrapping press count, and serves them on the IO read bus.
module io_input_port #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  io_input_port_if.slave   bus
);

  localparam int N_IN = N_BTN + N_SW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  meta_q;
  logic [N_IN-1:0]  sync_q;
  logic [N_IN-1:0]  db;
  logic [N_BTN-1:0] btn_db;
  logic [N_SW-1:0]  sw_db;

  assign raw    = {sw_in, btn_in};
  assign btn_db = db[N_BTN-1:0];
  assign sw_db  = db[N_IN-1:N_BTN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // One independent debouncer per input; any return to the accepted level restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             db_q, db_d;

      always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[gi] != db_q) begin
          if (cnt_q == CNT_LAST) begin
            db_d = sync_q[gi];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          db_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db[gi] = db_q;
    end
  endgenerate

  logic [N_BTN-1:0] btn_prev_q;
  logic [N_BTN-1:0] flag_q, flag_d;
  logic [15:0]      count_q, count_d;
  logic [N_BTN-1:0] rise;
  logic             clear;
  logic [4:0]       pop;

  assign rise  = btn_db & ~btn_prev_q;
  assign clear = bus.io_read_en && (bus.io_addr == 4'd2);

  // A press landing in the same cycle as a clear survives it.
  always_comb begin
    flag_d = (clear ? '0 : flag_q) | rise;
    pop    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      pop = pop + {4'd0, rise[i]};
    end
    count_d = count_q + 16'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_q <= '0;
      flag_q     <= '0;
      count_q    <= '0;
    end else begin
      btn_prev_q <= btn_db;
      flag_q     <= flag_d;
      count_q    <= count_d;
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (bus.io_addr)
      4'd0:    rdata[N_SW-1:0]  = sw_db;
      4'd1:    rdata[N_BTN-1:0] = btn_db;
      4'd2:    rdata[N_BTN-1:0] = flag_q;
      4'd3:    rdata[15:0]      = count_q;
      default: rdata = '0;
    endcase
  end

  assign bus.io_read_data  = rdata;
  assign bus.event_pending = |flag_q;

endmodule
